// File: rtl/conv2_pkg.sv
// Shared constants, index types and helpers for the conv2 ReLU/requant/pool stage.
// Optional build macro: CONV2_QROUND_EN (round-half-up requantization).
package conv2_pkg;
  localparam int NCH        = 16;
  localparam int ACC_W      = 30;
  localparam int BIAS_W     = 8;
  localparam int BIAS_SHIFT = 9;
  localparam int QSHIFT     = 12;
  localparam int OUT_W      = 8;
  localparam int MAP_W      = 42;
  localparam int MAP_H      = 30;
  localparam int POOL_W     = MAP_W / 2;
  localparam int POOL_H     = MAP_H / 2;

  typedef logic [$clog2(MAP_W)-1:0]  col_t;
  typedef logic [$clog2(MAP_H)-1:0]  row_t;
  typedef logic [$clog2(POOL_W)-1:0] pcol_t;
  typedef logic [$clog2(POOL_H)-1:0] prow_t;
  typedef logic [$clog2(NCH+1)-1:0]  bcnt_t;

  function automatic logic [OUT_W-1:0] umax(input logic [OUT_W-1:0] a, input logic [OUT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/conv2_requant.sv
// Per-channel bias add, ReLU, arithmetic right shift and unsigned 8-bit saturate.
// With CONV2_QROUND_EN defined, adds half an LSB before the shift (round half up).
module conv2_requant
  import conv2_pkg::*;
(
  input  logic [ACC_W-1:0]  acc,
  input  logic [BIAS_W-1:0] bias,
  output logic [OUT_W-1:0]  q
);
  localparam logic signed [32:0] RND = 33'sd1 <<< (QSHIFT - 1);

  logic signed [31:0] s;
  logic signed [32:0] sr;
  logic        [32:0] r;

  // Bias scaled to accumulator units, then ReLU + shift + saturate
  always_comb begin
    s = $signed({{(32-ACC_W){acc[ACC_W-1]}}, acc})
      + $signed({{(32-BIAS_W-BIAS_SHIFT){bias[BIAS_W-1]}}, bias, {BIAS_SHIFT{1'b0}}});
`ifdef CONV2_QROUND_EN
    sr = $signed({s[31], s}) + RND;
`else
    sr = $signed({s[31], s});
`endif
    r = sr >>> QSHIFT;
    if (s <= 0)             q = '0;
    else if (r > 33'd255)   q = '1;
    else                    q = r[OUT_W-1:0];
  end
endmodule

// File: rtl/conv2_relu_pool.sv
// conv2 post-processing: bias + ReLU + requant per channel, then 2x2/stride-2 max pool.
// Optional build macro: CONV2_QROUND_EN (selects rounding in conv2_requant).
module conv2_relu_pool
  import conv2_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [NCH*ACC_W-1:0]   in_data,
  input  logic                   b_en,
  input  logic [BIAS_W-1:0]      b_in,
  output logic                   bias_loaded,
  output logic                   out_valid,
  output logic [NCH*OUT_W-1:0]   out_data,
  output logic [3:0]             out_row,
  output logic [4:0]             out_col,
  output logic                   frame_done
);
  logic [BIAS_W-1:0]              bias [NCH];
  bcnt_t                          bias_cnt;
  col_t                           col, col1;
  row_t                           row, row1;
  logic                           v1;
  logic [NCH-1:0][OUT_W-1:0]      q, q1, hreg, h, od;
  logic [NCH-1:0][OUT_W-1:0]      lbuf [POOL_W];
  pcol_t                          pc1;

  assign bias_loaded = (bias_cnt == bcnt_t'(NCH));
  assign pc1         = pcol_t'(col1 >> 1);
  assign out_data    = od;
  assign frame_done  = out_valid && (out_row == 4'(POOL_H-1)) && (out_col == 5'(POOL_W-1));

  // Serial bias load, channel 0 first; writes past the last channel are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias_cnt <= '0;
      for (int k = 0; k < NCH; k++) bias[k] <= '0;
    end else if (b_en && !bias_loaded) begin
      for (int k = 0; k < NCH; k++)
        if (bias_cnt == bcnt_t'(k)) bias[k] <= b_in;
      bias_cnt <= bias_cnt + 1'b1;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_rq
    conv2_requant u_rq (
      .acc  (in_data[k*ACC_W +: ACC_W]),
      .bias (bias[k]),
      .q    (q[k])
    );
  end

  // Raster position of the incoming pixel; wraps at end of frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      if (col == col_t'(MAP_W-1)) begin
        col <= '0;
        row <= (row == row_t'(MAP_H-1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Stage 1: requantized pixel with its position tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      q1   <= '0;
      col1 <= '0;
      row1 <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        q1   <= q;
        col1 <= col;
        row1 <= row;
      end
    end
  end

  // Horizontal max of the current pixel pair
  always_comb begin
    for (int k = 0; k < NCH; k++) h[k] = umax(hreg[k], q1[k]);
  end

  // Pair holding register and line buffer; row-even writes always precede row-odd reads
  always_ff @(posedge clk) begin
    if (v1) begin
      if (!col1[0])      hreg      <= q1;
      else if (!row1[0]) lbuf[pc1] <= h;
    end
  end

  // Stage 2: vertical max closes each 2x2 window on its bottom-right pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      od        <= '0;
      out_row   <= '0;
      out_col   <= '0;
    end else begin
      out_valid <= 1'b0;
      if (v1 && col1[0] && row1[0]) begin
        for (int k = 0; k < NCH; k++) od[k] <= umax(lbuf[pc1][k], h[k]);
        out_valid <= 1'b1;
        out_row   <= 4'(row1 >> 1);
        out_col   <= pc1;
      end
    end
  end
endmodule

// File: tb/tb_conv2_relu_pool.sv
// Self-checking bench for conv2_relu_pool: frame-level model plus directed literal checks.
module tb_conv2_relu_pool;
  localparam int NCH = 16, ACC_W = 30, OUT_W = 8, MW = 42, MH = 30, PW = 21, NP = 315;

  logic                  clk = 1'b0, rst_n;
  logic                  in_valid, b_en, bias_loaded, out_valid, frame_done;
  logic [NCH*ACC_W-1:0]  in_data;
  logic [7:0]            b_in;
  logic [NCH*OUT_W-1:0]  out_data;
  logic [3:0]            out_row;
  logic [4:0]            out_col;

  conv2_relu_pool dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .b_en(b_en), .b_in(b_in), .bias_loaded(bias_loaded), .out_valid(out_valid),
    .out_data(out_data), .out_row(out_row), .out_col(out_col), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [NCH*OUT_W-1:0] d; int r; int c; bit fd; } exp_t;
  exp_t eq[$];

  int checks = 0, fails = 0, cyc = 0;
  int n_out, n_fd, first_r, first_c;
  logic [NCH*OUT_W-1:0] cap [NP];
  logic [7:0] qm [MH][MW][NCH];
  logic signed [7:0] bias_m [NCH];
  int bcnt_m, row_m, col_m;

`ifdef CONV2_QROUND_EN
  localparam int Q4095 = 1, Q15B = 2;
`else
  localparam int Q4095 = 0, Q15B = 1;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference requant from plain integer arithmetic
  function automatic logic [7:0] mq(input longint acc, input longint b);
    longint s, r;
    s = acc + b * 512;
    if (s <= 0) return 8'd0;
`ifdef CONV2_QROUND_EN
    r = (s + 2048) / 4096;
`else
    r = s / 4096;
`endif
    return (r > 255) ? 8'd255 : 8'(r);
  endfunction

  function automatic logic [7:0] capb(input int idx, input int k);
    logic [NCH*OUT_W-1:0] v;
    v = cap[idx];
    return v[k*8 +: 8];
  endfunction

  task automatic model_pixel(input logic [NCH*ACC_W-1:0] d);
    exp_t e;
    longint a;
    for (int k = 0; k < NCH; k++) begin
      a = $signed(d[k*ACC_W +: ACC_W]);
      qm[row_m][col_m][k] = mq(a, longint'(bias_m[k]));
    end
    if (row_m % 2 == 1 && col_m % 2 == 1) begin
      e.due = cyc + 2; e.r = row_m / 2; e.c = col_m / 2;
      e.fd = (e.r == 14 && e.c == 20);
      e.d = '0;
      for (int k = 0; k < NCH; k++) begin
        logic [7:0] m;
        m = qm[row_m-1][col_m-1][k];
        if (qm[row_m-1][col_m][k] > m) m = qm[row_m-1][col_m][k];
        if (qm[row_m][col_m-1][k] > m) m = qm[row_m][col_m-1][k];
        if (qm[row_m][col_m][k] > m)   m = qm[row_m][col_m][k];
        e.d[k*8 +: 8] = m;
      end
      eq.push_back(e);
    end
    col_m++;
    if (col_m == MW) begin col_m = 0; row_m = (row_m + 1) % MH; end
  endtask

  task automatic step(input bit v, input logic [NCH*ACC_W-1:0] d, input bit be, input logic [7:0] bv);
    @(negedge clk);
    in_valid = v; in_data = d; b_en = be; b_in = bv;
    if (v) model_pixel(d);
    if (be && bcnt_m < 16) begin bias_m[bcnt_m] = bv; bcnt_m++; end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 8'd0);
  endtask

  task automatic clear_stats();
    n_out = 0; n_fd = 0; first_r = -1; first_c = -1;
    for (int i = 0; i < NP; i++) cap[i] = '1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0; in_valid = 1'b0; b_en = 1'b0;
    eq.delete();
    row_m = 0; col_m = 0; bcnt_m = 0;
    for (int k = 0; k < NCH; k++) bias_m[k] = '0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", (out_data != 0), 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_col", out_col, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_bias_loaded", bias_loaded, 0);
    rst_n = 1'b1;
  endtask

  function automatic logic [NCH*ACC_W-1:0] fill(input int v);
    logic [NCH*ACC_W-1:0] d;
    for (int k = 0; k < NCH; k++) d[k*ACC_W +: ACC_W] = 30'(v);
    return d;
  endfunction

  function automatic logic [NCH*ACC_W-1:0] pat(input int r, input int c, input bit z3);
    logic [NCH*ACC_W-1:0] d;
    int v;
    for (int k = 0; k < NCH; k++) begin
      v = (((r*13 + c*7 + k*11) % 600) - 100) * 1000;
      if (z3 && k == 3) v = 0;
      d[k*ACC_W +: ACC_W] = 30'(v);
    end
    return d;
  endfunction

  // Output checker: every cycle, against the frame model's expectation queue
  always @(negedge clk) begin
    while (eq.size() > 0 && eq[0].due < cyc) begin
      checks++; fails++;
      $display("FAIL missing_out: got none expected (%0d,%0d) due %0d", eq[0].r, eq[0].c, eq[0].due);
      void'(eq.pop_front());
    end
    if (out_valid) begin
      checks++;
      if (eq.size() == 0 || eq[0].due != cyc) begin
        fails++;
        $display("FAIL unexpected_out: got (%0d,%0d) at cycle %0d expected no strobe", out_row, out_col, cyc);
      end else begin
        exp_t e;
        e = eq.pop_front();
        chk("out_data_mismatch", (out_data == e.d) ? 1 : 0, 1);
        if (out_data != e.d) $display("  data got %h expected %h", out_data, e.d);
        chk("out_row", out_row, e.r);
        chk("out_col", out_col, e.c);
        chk("frame_done_strobe", frame_done, e.fd);
      end
      if (n_out == 0) begin first_r = out_row; first_c = out_col; end
      n_out++;
      if (frame_done) n_fd++;
      if (int'(out_row) * PW + int'(out_col) < NP) cap[int'(out_row) * PW + int'(out_col)] = out_data;
    end else begin
      chk("frame_done_idle", frame_done, 0);
    end
  end

  int tbl [4][4] = '{'{1,2,3,9}, '{9,1,2,3}, '{1,9,2,3}, '{1,2,9,3}};

  initial begin
    logic [NCH*ACC_W-1:0] d;
    int w, p;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; b_en = 1'b0; b_in = '0;
    row_m = 0; col_m = 0; bcnt_m = 0;
    clear_stats();
    repeat (2) @(negedge clk);
    do_reset();

    // Bias load: k into channel k, then 3 ignored writes
    for (int k = 0; k < NCH; k++) begin
      step(1'b0, '0, 1'b1, 8'(k));
      if (k == 15) chk("bias_loaded_after15", bias_loaded, 0);
    end
    step(1'b0, '0, 1'b1, 8'd100);
    chk("bias_loaded_after16", bias_loaded, 1);
    step(1'b0, '0, 1'b1, 8'd100);
    step(1'b0, '0, 1'b1, 8'd100);
    for (int i = 0; i < 44; i++) step(1'b1, '0, 1'b0, 8'd0);
    idle(3);
    chk("bias_ch8", capb(0, 8), 1);
    chk("bias_ch15_extra_ignored", capb(0, 15), Q15B);
    chk("bias_ch0", capb(0, 0), 0);

    // Constant frame, zero biases
    do_reset();
    clear_stats();
    for (int i = 0; i < MW*MH; i++) step(1'b1, fill(4096*5), 1'b0, 8'd0);
    idle(3);
    chk("const_outs", n_out, NP);
    chk("const_frame_done", n_fd, 1);
    chk("const_first_row", first_r, 0);
    chk("const_first_col", first_c, 0);
    chk("const_last_ch0", capb(NP-1, 0), 5);
    chk("const_last_ch15", capb(NP-1, 15), 5);
    chk("const_mid_ch7", capb(7*PW+10, 7), 5);

    // Directed windows: max position, ReLU, saturation, bias -1 on ch3
    do_reset();
    clear_stats();
    for (int k = 0; k < NCH; k++) step(1'b0, '0, 1'b1, (k == 3) ? 8'hFF : 8'h00);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < MW; c++) begin
        d = '0; w = c / 2; p = (r % 2) * 2 + (c % 2);
        if (w < 4) d[0 +: ACC_W] = 30'(tbl[w][p] * 4096);
        else if (w == 4) begin
          d[0*ACC_W +: ACC_W] = 30'(-1000);
          d[1*ACC_W +: ACC_W] = 30'((1 << 29) - 1);
          d[2*ACC_W +: ACC_W] = 30'(4095);
          d[3*ACC_W +: ACC_W] = 30'(512);
        end
        step(1'b1, d, 1'b0, 8'd0);
      end
    idle(3);
    chk("max_br", capb(0, 0), 9);
    chk("max_tl", capb(1, 0), 9);
    chk("max_tr", capb(2, 0), 9);
    chk("max_bl", capb(3, 0), 9);
    chk("relu_neg", capb(4, 0), 0);
    chk("sat_255", capb(4, 1), 255);
    chk("q_4095", capb(4, 2), Q4095);
    chk("bias_neg_ch3", capb(4, 3), 0);
    for (int i = 84; i < 500; i++) step(1'b1, pat(i / MW, i % MW, 1'b0), 1'b0, 8'd0);

    // Reset mid-frame, reload biases (ch3 = 8), full frame
    do_reset();
    clear_stats();
    for (int k = 0; k < NCH; k++) step(1'b0, '0, 1'b1, (k == 3) ? 8'd8 : 8'd0);
    for (int i = 0; i < MW*MH; i++) step(1'b1, pat(i / MW, i % MW, 1'b1), 1'b0, 8'd0);
    idle(3);
    chk("restart_outs", n_out, NP);
    chk("restart_frame_done", n_fd, 1);
    chk("restart_first_row", first_r, 0);
    chk("restart_first_col", first_c, 0);
    chk("bias_pos_ch3", capb(0, 3), 1);
    chk("queue_drained", eq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/conv2_relu_pool.md
Name: conv2_relu_pool

Overview:
- Downstream stage of the conv2 16-channel multiply-accumulate block.
- Consumes one 16x30-bit signed partial-sum vector per output pixel of the 30-row x 42-column conv2 feature map (1260 pixels, raster order).
- Per channel: adds bias, applies ReLU, requantizes to 8 bits, then runs 2x2/stride-2 max-pooling.
- Emits a 15x21 pooled map of 16x8-bit vectors to the flatten/FC stage.

Parameters:
- NCH, 16, number of channels
- ACC_W, 30, width of each signed input partial sum
- BIAS_W, 8, signed bias width
- BIAS_SHIFT, 9, left shift applied to bias to match accumulator scale
- QSHIFT, 12, arithmetic right shift for requantization
- OUT_W, 8, output width per channel
- MAP_W, 42, conv2 map columns (even)
- MAP_H, 30, conv2 map rows (even)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  one-cycle strobe; in_data holds one pixel for all channels
- in_data  in  NCH*ACC_W  signed partial sums; channel k at bits [ACC_W*(k+1)-1 : ACC_W*k]
- b_en  in  1  bias write strobe
- b_in  in  BIAS_W  signed bias value, written serially channel 0..15
- bias_loaded  out  1  high once 16 biases have been written
- out_valid  out  1  one-cycle strobe per pooled pixel
- out_data  out  NCH*OUT_W  pooled unsigned values, same channel packing as in_data
- out_row  out  4  pooled row index, 0..14
- out_col  out  5  pooled column index, 0..20
- frame_done  out  1  one-cycle pulse with the last pooled pixel (14,20)

Behaviour:
- Reset: all outputs 0; bias registers 0; bias_cnt, col, row 0; pipeline valids 0.
- Bias load: each b_en cycle writes b_in to bias[bias_cnt] and increments bias_cnt, saturating at 16.
  - bias_loaded = (bias_cnt == 16).
  - b_en beyond 16 writes is ignored.
  - b_en coinciding with in_valid is legal. The pixel uses bias values as registered before that edge.
- Stage 1 (requant), registered on in_valid:
  - s = sext(in_data[k]) + (sext(bias[k]) << BIAS_SHIFT), 32-bit signed.
  - r = (s <= 0) ? 0 : s >>> QSHIFT.
  - q = (r > 255) ? 255 : r[7:0]. Unsigned saturate.
  - v1 <= in_valid.
  - Stage-1 position tags: col1 and row1 hold the col and row counter values latched on in_valid.
- Position counters advance on each in_valid:
  - col 0..MAP_W-1; wraps to 0 and increments row.
  - row 0..MAP_H-1; wraps to 0 after pixel (29,41).
  - Wrap is automatic; no restart input.
- Stage 2 (pool), acting on v1:
  - col1 even: hreg[k] <= q.
  - col1 odd: h = max(hreg[k], q).
    - row1 even: linebuf[col1>>1][k] <= h.
    - row1 odd: out_data[k] <= max(linebuf[col1>>1][k], h); out_valid <= 1; out_row <= row1>>1; out_col <= col1>>1.
  - out_valid is 0 in every other cycle.
  - out_data, out_row and out_col hold their values between strobes.
- Latency: out_valid rises 2 clk edges after the in_valid of the bottom-right pixel of each 2x2 window.
- Throughput: back-to-back in_valid on every cycle is supported. There is no backpressure.
- frame_done = out_valid && out_row == 14 && out_col == 20.
- Line buffer: 21 x NCH x OUT_W flops. Row-even writes always precede row-odd reads, so no initialization is needed.
- Reset mid-frame: counters return to 0; the next in_valid is treated as pixel (0,0). Bias registers also clear and must be reloaded.

Optional Feature:
- Macro: CONV2_QROUND_EN.
- Defined: round-half-up before the shift. For s > 0, r = (s + (1 << (QSHIFT-1))) >>> QSHIFT, computed in 33 bits, then saturated as above.
- Undefined: truncating shift as specified in Behaviour.

Decomposition:
- Shared package conv2_pkg:
  - Constants NCH, ACC_W, OUT_W, MAP_W, MAP_H, POOL_W = MAP_W/2, POOL_H = MAP_H/2.
  - Typedefs for the pooled index widths.
- One sub-module, conv2_requant: per-channel combinational bias-add, ReLU, shift, round and saturate. Instantiated NCH times.
- Counters, line buffer and pooling logic stay in the top module.

Test Plan:
- Bias load then status: write biases 0..15 = k, then 3 further b_en -> bias_loaded = 1 after the 16th write; bias[15] = 15; extra writes ignored.
- Constant frame: biases 0, all in_data = 4096*5 for all 1260 pixels -> 315 out_valid pulses; every byte = 5; frame_done only on (14,20).
- ReLU and saturation:
  - ch0 = -1000 -> 0.
  - ch1 = 2^29-1 -> 255.
  - ch2 = 4095 -> 0 without macro, 1 with CONV2_QROUND_EN.
- Max selection: first window pixels ch0 = 1, 2, 3, 9 (x4096; (0,0), (0,1), (1,0), (1,1)) -> first out_data ch0 = 9 at (0,0), 2 cycles after the 4th pixel. Repeat with the maximum in each of the other three positions.
- Bias path: bias ch3 = -1, in_data ch3 = 512 -> 0; bias ch3 = 8, in_data ch3 = 0 -> 4096 >> 12 = 1.
- Reset mid-frame after 500 pixels, reload biases, send a full frame -> exactly 315 outputs, indices starting at (0,0), single frame_done.
